// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_pkg.sv
// Shared types, constants and helpers for the programmable clock divider.
// Ratios are handled as 32-bit values here; callers truncate to their WIDTH.
package gf180mcu_fd_sc_mcu7t5v0__clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam int unsigned DIV_MIN = 2;

  // Ratios below DIV_MIN cannot form a high and a low phase, so they run as DIV_MIN.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < DIV_MIN) ? DIV_MIN : div;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_ratio.sv
// Pending/active divide-ratio registers. A loaded ratio waits in pending and
// is promoted to active only on a period wrap or on a start from idle.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_ratio
  import gf180mcu_fd_sc_mcu7t5v0__clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DIV_RST = 2
) (
  input  logic             clk,
  input  logic             rn,
  input  logic             ld,
  input  logic [WIDTH-1:0] div,
  input  logic             wrap,
  input  logic             start,
  output logic [WIDTH-1:0] active,
  output logic [WIDTH-1:0] active_next,
  output logic             busy
);

  localparam logic [WIDTH-1:0] RST_RATIO = WIDTH'(clamp_div(DIV_RST));

  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             busy_q, busy_d;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    pending_d = pending_q;
    active_d  = active_q;
    busy_d    = busy_q;
    if (wrap || start) begin
      active_d = pending_q;
      busy_d   = 1'b0;
    end
    // A load coincident with a boundary still queues: the old pending applies now.
    if (ld) begin
      pending_d = WIDTH'(clamp_div(32'(div)));
      busy_d    = 1'b1;
    end
  end

  // NOTE: reset is synchronous (only tested inside the clocked branch); sequential state uses <= only.
  always_ff @(posedge clk) begin
    if (!rn) begin
      pending_q <= RST_RATIO;
      active_q  <= RST_RATIO;
      busy_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      active_q  <= active_d;
      busy_q    <= busy_d;
    end
  end

  assign active      = active_q;
  assign active_next = active_d;
  assign busy        = busy_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog.sv
// Programmable clock divider: FSM, period counter and registered Z/ZE outputs.
// Ratio changes and stop requests only take effect on period boundaries.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog
  import gf180mcu_fd_sc_mcu7t5v0__clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DIV_RST    = 2,
  parameter bit          PULSE_MODE = 1'b0
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic             LD,
  input  logic [WIDTH-1:0] DIV,
  output logic             Z,
  output logic             ZE,
  output logic             BUSY
);

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_W = (WIDTH+1)'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             z_q, z_d;
  logic             ze_q, ze_d;

  logic [WIDTH-1:0] ratio, ratio_next;
  logic             busy;
  logic             at_end, wrap, start, running_d;
  logic [WIDTH:0]   half_next;

  gf180mcu_fd_sc_mcu7t5v0__clkdiv_ratio #(
    .WIDTH   (WIDTH),
    .DIV_RST (DIV_RST)
  ) u_ratio (
    .clk         (CLK),
    .rn          (RN),
    .ld          (LD),
    .div         (DIV),
    .wrap        (wrap),
    .start       (start),
    .active      (ratio),
    .active_next (ratio_next),
    .busy        (busy)
  );

  assign at_end = (cnt_q == ratio - ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (EN) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        cnt_d = at_end ? '0 : cnt_q + ONE;
        wrap  = at_end;
        if (!EN) state_d = STOP;
      end
      STOP: begin
        cnt_d = at_end ? '0 : cnt_q + ONE;
        wrap  = at_end;
        if (EN)          state_d = RUN;
        else if (at_end) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the post-edge count and ratio, then registered.
  always_comb begin
    running_d = (state_d != IDLE);
    half_next = ({1'b0, ratio_next} + ONE_W) >> 1;
    if (PULSE_MODE) z_d = running_d && (cnt_d == '0);
    else            z_d = running_d && ({1'b0, cnt_d} < half_next);
    ze_d = running_d && (cnt_d == ratio_next - ONE);
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      z_q     <= 1'b0;
      ze_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      ze_q    <= ze_d;
    end
  end

  assign Z    = z_q;
  assign ZE   = ze_q;
  assign BUSY = busy;

`ifndef FUNCTIONAL
  specify
    (CLK => Z)  = (1.0, 1.0);
    (CLK => ZE) = (1.0, 1.0);
  endspecify
`endif

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog.md
Name: gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog

Overview:
- Parametrised, programmable clock divider. It is the sequential successor to the fixed clock buffer cells in the mcu7t5v0 library.
- Generates a registered divided clock Z plus a single-cycle period strobe ZE from CLK.
- The divide ratio is runtime-loadable. Ratio changes and enable/disable take effect only on period boundaries, so Z never produces a runt pulse.
- Sits at the root of low-speed clock/enable trees: peripheral clocks, ADC sample enables.

Parameters:
- WIDTH, 8, width of DIV and of the internal period counter.
- DIV_RST, 2, active divide ratio after reset; must be at least 2.
- PULSE_MODE, 0, 0 = near-50% duty Z; 1 = Z high for exactly one CLK cycle per period.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RN  input  1  reset, synchronous, active-low.
- EN  input  1  run request; sampled every cycle.
- LD  input  1  load strobe; captures DIV into the pending-ratio register.
- DIV  input  WIDTH  requested divide ratio N; values 0 and 1 are clamped to 2.
- Z  output  1  divided clock, registered.
- ZE  output  1  one-cycle strobe in the last CLK cycle of each Z period, registered.
- BUSY  output  1  a loaded ratio is pending and not yet applied.
- VDD, VSS  inout  1  power pins, present only under USE_POWER_PINS.

Behaviour:
- One clock, CLK. Reset RN is synchronous and active-low; it is honoured only at a CLK rising edge while RN=0.
- Reset values:
  - state = IDLE, cnt = 0, active ratio = DIV_RST, pending = DIV_RST.
  - Z = 0, ZE = 0, BUSY = 0.
- RN=0 mid-period aborts immediately; any pending load is discarded.
- State machine:
  - IDLE: EN=1 -> RUN, cnt = 0, Z = 1 at that same edge. Otherwise stay in IDLE with Z = 0, ZE = 0.
  - RUN: EN=0 -> STOP; the current period continues unaltered.
  - STOP: at the boundary edge (cnt = N-1) -> IDLE with Z = 0. If EN=1 before the boundary, return to RUN with no change to cnt or Z.
- Counter: in RUN/STOP, cnt increments 0..N-1 and wraps to 0 at N-1. The period is exactly N CLK cycles.
- Z value is computed from the post-edge cnt:
  - PULSE_MODE=0: Z = 1 while cnt < ceil(N/2). Example: N = 5 gives 3 cycles high, 2 low.
  - PULSE_MODE=1: Z = 1 only while cnt = 0.
- ZE = 1 exactly during the cycle where cnt = N-1, in RUN/STOP. ZE is 0 in IDLE.
- Ratio loading:
  - LD=1 at an edge: pending = clamp(DIV), BUSY = 1.
  - At the next wrap edge (cnt N-1 -> 0), or at an IDLE->RUN edge: active = pending, BUSY = 0. The new period starts with the new ratio.
  - LD again while BUSY overwrites pending; the last load wins.
  - LD on the same edge as a wrap: the newly sampled value becomes pending and applies at the following wrap. The old pending value is applied at this wrap.
  - LD in IDLE: BUSY = 1 until the next IDLE->RUN edge.
- Width rules:
  - Comparisons are unsigned in WIDTH bits; ceil(N/2) = (N+1)>>1, computed in WIDTH+1 bits.
  - N = 2^WIDTH-1 is legal; cnt never overflows.
- Outputs never change except at CLK edges. No combinational path from any input to any output.

Decomposition:
- Shared package gf180mcu_fd_sc_mcu7t5v0__clkdiv_pkg:
  - state enum {IDLE, RUN, STOP}.
  - Constant DIV_MIN = 2.
  - Function clamp_div.
- One natural sub-module, gf180mcu_fd_sc_mcu7t5v0__clkdiv_ratio: pending/active ratio registers with BUSY logic. Its interface is LD, DIV, wrap, start -> active ratio, BUSY.
- The top level holds the FSM, counter and output registers.
- A specify block gives CLK->Z and CLK->ZE arcs of (1.0,1.0) under `ifndef FUNCTIONAL.

Test Plan:
- Reset, then EN=1 with default N=2 -> Z toggles 1,0,1,0; ZE high on every second cycle; BUSY=0.
- LD with DIV=5 while running at N=2 -> BUSY=1 until the next wrap. From that wrap Z follows 1,1,1,0,0 repeating, ZE on the 5th cycle, BUSY=0.
- EN=0 at cnt=1 of an N=6 period -> Z completes 1,1,1,0,0,0 then stays 0 and the FSM is in IDLE. A re-raise of EN at cnt=3 instead keeps Z uninterrupted.
- DIV=0 and DIV=1 loads -> behaves exactly as N=2. DIV=255 with WIDTH=8 -> period 255, Z high 128 cycles.
- PULSE_MODE=1, N=4 -> Z = 1,0,0,0 and ZE = 0,0,0,1 repeating. Then RN=0 mid-period -> next cycle Z=0, ZE=0, BUSY=0, ratio back to DIV_RST.
- Back-to-back LD of 3 then 7 within one period, with the second LD coincident with a wrap -> ratio 3 applied at that wrap, 7 applied at the following wrap.
